// File: rtl/pe_merge.sv
// Merges NACC accumulator words then one psum word into a registered output stream.
// Optional PE_MERGE_PSUM_CNT_EN adds a 16-bit count of psum words forwarded.
module pe_merge #(
   parameter int DWIDTH = 8,
   parameter int NACC   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              acc_valid,
   output logic              acc_ready,
   input  logic [DWIDTH-1:0] acc_data,
   input  logic              pkt_valid,
   output logic              pkt_ready,
   input  logic [DWIDTH-1:0] pkt_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] out_data,
`ifdef PE_MERGE_PSUM_CNT_EN
   output logic [15:0]       psum_cnt,
`endif
   output logic              out_last
);

   typedef enum logic {S_ACC = 1'b0, S_PKT = 1'b1} state_t;

   localparam logic [3:0] ACC_LAST = 4'(NACC - 1);

   state_t     state, state_nxt;
   logic [3:0] acc_idx, acc_idx_nxt;
   logic       live;
   logic       free;
   logic       acc_xfer, pkt_xfer;

   assign free     = !out_valid || out_ready;
   assign acc_xfer = acc_valid && acc_ready;
   assign pkt_xfer = pkt_valid && pkt_ready;

   // live holds readys off until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_ACC;
         acc_idx <= 4'd0;
         live    <= 1'b0;
      end else begin
         state   <= state_nxt;
         acc_idx <= acc_idx_nxt;
         live    <= 1'b1;
      end
   end

   always_comb begin
      state_nxt   = state;
      acc_idx_nxt = acc_idx;
      if (acc_xfer) begin
         if (acc_idx == ACC_LAST) begin
            acc_idx_nxt = 4'd0;
            state_nxt   = S_PKT;
         end else begin
            acc_idx_nxt = acc_idx + 4'd1;
         end
      end else if (pkt_xfer) begin
         state_nxt = S_ACC;
      end
   end

   always_comb begin
      acc_ready = 1'b0;
      pkt_ready = 1'b0;
      if (live && free) begin
         acc_ready = (state == S_ACC);
         pkt_ready = (state == S_PKT);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else if (acc_xfer) begin
         out_valid <= 1'b1;
         out_last  <= 1'b0;
         out_data  <= acc_data;
      end else if (pkt_xfer) begin
         out_valid <= 1'b1;
         out_last  <= 1'b1;
         out_data  <= pkt_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef PE_MERGE_PSUM_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        psum_cnt <= 16'd0;
      else if (pkt_xfer) psum_cnt <= psum_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_pe_merge.sv
// Directed bench for pe_merge: NACC=2 instance for ordering/backpressure/reset,
// NACC=1 instance for strict alternation.
module tb_pe_merge;

   logic       clk = 1'b0;
   logic       rst_n;
   int         checks = 0;
   int         errors = 0;

   logic       acc_valid, acc_ready, pkt_valid, pkt_ready;
   logic       out_valid, out_ready, out_last;
   logic [7:0] acc_data, pkt_data, out_data;

   logic       b_acc_valid, b_acc_ready, b_pkt_valid, b_pkt_ready;
   logic       b_out_valid, b_out_ready, b_out_last;
   logic [7:0] b_acc_data, b_pkt_data, b_out_data;

`ifdef PE_MERGE_PSUM_CNT_EN
   logic [15:0] psum_a, psum_b;
`endif

   int n22 = 0;

   always #5 clk = ~clk;

   pe_merge #(.DWIDTH(8), .NACC(2)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef PE_MERGE_PSUM_CNT_EN
      .psum_cnt(psum_a),
`endif
      .out_last(out_last)
   );

   pe_merge #(.DWIDTH(8), .NACC(1)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .acc_valid(b_acc_valid), .acc_ready(b_acc_ready), .acc_data(b_acc_data),
      .pkt_valid(b_pkt_valid), .pkt_ready(b_pkt_ready), .pkt_data(b_pkt_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
`ifdef PE_MERGE_PSUM_CNT_EN
      .psum_cnt(psum_b),
`endif
      .out_last(b_out_last)
   );

   // counts downstream handshakes of the held word 0x22
   always @(posedge clk)
      if (out_valid && out_ready && out_data == 8'h22) n22 <= n22 + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic l);
      check({tag, "_valid"}, 32'(out_valid), 32'(v));
      check({tag, "_data"},  32'(out_data),  32'(d));
      check({tag, "_last"},  32'(out_last),  32'(l));
   endtask

   initial begin
      logic a_hs, p_hs;
      int   ai, pi;

      rst_n = 1'b0;
      acc_valid = 1'b1; acc_data = 8'hEE; pkt_valid = 1'b1; pkt_data = 8'hEF;
      out_ready = 1'b1;
      b_acc_valid = 1'b0; b_acc_data = 8'h00; b_pkt_valid = 1'b0; b_pkt_data = 8'h00;
      b_out_ready = 1'b1;
      tick(); tick();
      // reset state
      chk_out("rst", 1'b0, 8'h00, 1'b0);
      check("rst_acc_ready", 32'(acc_ready), 32'd0);
      check("rst_pkt_ready", 32'(pkt_ready), 32'd0);
      acc_valid = 1'b0; pkt_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      check("rel_acc_ready_pre_edge", 32'(acc_ready), 32'd0);
      tick();
      check("rel_acc_ready_post_edge", 32'(acc_ready), 32'd1);
      check("rel_pkt_ready_post_edge", 32'(pkt_ready), 32'd0);

      // basic group 0x11,0x22,0x33
      acc_valid = 1'b1; acc_data = 8'h11;
      tick(); chk_out("g1_w0", 1'b1, 8'h11, 1'b0);
      acc_data = 8'h22;
      tick(); chk_out("g1_w1", 1'b1, 8'h22, 1'b0);
      check("g1_acc_ready_pkt_phase", 32'(acc_ready), 32'd0);
      check("g1_pkt_ready_pkt_phase", 32'(pkt_ready), 32'd1);
      acc_valid = 1'b0; pkt_valid = 1'b1; pkt_data = 8'h33;
      tick(); chk_out("g1_w2", 1'b1, 8'h33, 1'b1);
      pkt_valid = 1'b0;
      tick(); chk_out("g1_drain", 1'b0, 8'h33, 1'b1);

      // early pkt must wait behind the acc words
      pkt_valid = 1'b1; pkt_data = 8'h55;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("g2_pkt_wait_ready", 32'(pkt_ready), 32'd0);
         check("g2_pkt_wait_valid", 32'(out_valid), 32'd0);
      end
      acc_valid = 1'b1; acc_data = 8'h01;
      tick(); chk_out("g2_w0", 1'b1, 8'h01, 1'b0);
      check("g2_pkt_ready_mid", 32'(pkt_ready), 32'd0);
      acc_data = 8'h02;
      tick(); chk_out("g2_w1", 1'b1, 8'h02, 1'b0);
      acc_valid = 1'b0;
      tick(); chk_out("g2_w2", 1'b1, 8'h55, 1'b1);
      pkt_valid = 1'b0;
      tick();

      // backpressure while 0x22 is held
      acc_valid = 1'b1; acc_data = 8'h21;
      tick(); chk_out("g3_w0", 1'b1, 8'h21, 1'b0);
      acc_data = 8'h22;
      tick(); chk_out("g3_w1", 1'b1, 8'h22, 1'b0);
      n22 = 0;
      out_ready = 1'b0; acc_valid = 1'b0; pkt_valid = 1'b1; pkt_data = 8'h23;
      #1;
      for (int i = 0; i < 5; i++) begin
         check("g3_hold_acc_ready", 32'(acc_ready), 32'd0);
         check("g3_hold_pkt_ready", 32'(pkt_ready), 32'd0);
         tick();
         chk_out("g3_hold", 1'b1, 8'h22, 1'b0);
      end
      out_ready = 1'b1;
      tick(); chk_out("g3_w2", 1'b1, 8'h23, 1'b1);
      pkt_valid = 1'b0;
      tick();
      check("g3_n22_once", 32'(n22), 32'd1);

      // reset mid-group discards partial group
      acc_valid = 1'b1; acc_data = 8'hAA;
      tick(); chk_out("g4_pre", 1'b1, 8'hAA, 1'b0);
      acc_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("g4_rst_valid", 32'(out_valid), 32'd0);
      check("g4_rst_acc_ready", 32'(acc_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      acc_valid = 1'b1; acc_data = 8'hB1;
      tick(); chk_out("g4_w0", 1'b1, 8'hB1, 1'b0);
      check("g4_idx_restart", 32'(acc_ready), 32'd1);
      acc_data = 8'hB2;
      tick(); chk_out("g4_w1", 1'b1, 8'hB2, 1'b0);
      acc_valid = 1'b0; pkt_valid = 1'b1; pkt_data = 8'hB3;
      tick(); chk_out("g4_w2", 1'b1, 8'hB3, 1'b1);
      pkt_valid = 1'b0;
      tick();
`ifdef PE_MERGE_PSUM_CNT_EN
      check("psum_cnt_after_reset", 32'(psum_a), 32'd1);
`endif

      // NACC=1: both streams always valid, strict alternation
      ai = 0; pi = 0;
      b_acc_valid = 1'b1; b_pkt_valid = 1'b1;
      b_acc_data = 8'hA0; b_pkt_data = 8'hC0;
      for (int k = 0; k < 8; k++) begin
         #1;
         check("alt_ready_excl", 32'(b_acc_ready & b_pkt_ready), 32'd0);
         a_hs = b_acc_ready; p_hs = b_pkt_ready;
         tick();
         if (k % 2 == 0) begin
            check("alt_acc_data", 32'(b_out_data), 32'h0A0 + 32'(k / 2));
            check("alt_acc_last", 32'(b_out_last), 32'd0);
         end else begin
            check("alt_pkt_data", 32'(b_out_data), 32'h0C0 + 32'(k / 2));
            check("alt_pkt_last", 32'(b_out_last), 32'd1);
         end
         check("alt_valid", 32'(b_out_valid), 32'd1);
         if (a_hs) ai++;
         if (p_hs) pi++;
         b_acc_data = 8'hA0 + 8'(ai);
         b_pkt_data = 8'hC0 + 8'(pi);
      end
      b_acc_valid = 1'b0; b_pkt_valid = 1'b0;
      tick();
`ifdef PE_MERGE_PSUM_CNT_EN
      check("psum_cnt_b", 32'(psum_b), 32'd4);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pe_merge.md
PE_MERGE -- requirements
Module: pe_merge

Interface
REQ-001 Parameter: DWIDTH, default 8, width of every data word.
REQ-002 Parameter: NACC, default 2, accumulation words forwarded before each psum word; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 acc_valid  input  1  accumulator result word available.
REQ-006 acc_ready  output  1  block accepts acc_data this cycle.
REQ-007 acc_data  input  DWIDTH  accumulator result word.
REQ-008 pkt_valid  input  1  depacketized psum word available.
REQ-009 pkt_ready  output  1  block accepts pkt_data this cycle.
REQ-010 pkt_data  input  DWIDTH  psum word from depacketizer.
REQ-011 out_valid  output  1  merged stream word valid; feeds a PE split stage.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 out_data  output  DWIDTH  merged stream word, registered.
REQ-014 out_last  output  1  high with the psum word that closes each NACC+1-word group.

Function
REQ-015 A transfer on any channel SHALL occur only on a rising edge where valid and ready are both high.
REQ-016 FSM SHALL have two states: S_ACC (with 4-bit counter acc_idx) and S_PKT.
REQ-017 Output register is "free" when out_valid is low or out_ready is high in the same cycle.
REQ-018 acc_ready SHALL be high only in S_ACC with the output register free; pkt_ready only in S_PKT with it free; never both high.
REQ-019 On an acc transfer: out_data<=acc_data, out_valid<=1, out_last<=0; if acc_idx==NACC-1, acc_idx<=0 and state<=S_PKT, else acc_idx increments.
REQ-020 On a pkt transfer: out_data<=pkt_data, out_valid<=1, out_last<=1, state<=S_ACC.
REQ-021 With out_valid and out_ready high and no input transfer, out_valid SHALL clear next edge; out_data retains its value.
REQ-022 While out_valid high and out_ready low, out_data, out_last and out_valid SHALL hold and both input readys SHALL be low.
REQ-023 Latency: input transfer to out_valid is exactly one cycle; sustained throughput one word per cycle when out_ready held high.
REQ-024 Off-phase valid (pkt_valid in S_ACC, acc_valid in S_PKT) SHALL not be consumed or dropped; word stays pending at source.
REQ-025 Simultaneous acc_valid and pkt_valid: only the current-phase channel is served.
REQ-026 Output order per group SHALL be strictly NACC acc words then one pkt word; no reordering.
REQ-027 Readys are combinational from state and out_valid/out_ready only, never from the input valids.

Reset
REQ-028 While rst_n low: out_valid=0, out_last=0, out_data=0, state=S_ACC, acc_idx=0, acc_ready=0, pkt_ready=0.
REQ-029 Reset asserted mid-group SHALL discard the partial group; first acc word after release is group index 0.
REQ-030 Readys SHALL not assert before the first rising clk edge after rst_n deasserts.

Configuration
REQ-031 Macro PE_MERGE_PSUM_CNT_EN defined: extra output psum_cnt [15:0], reset 0, increments on each pkt transfer, wraps 0xFFFF->0x0000.
REQ-032 Macro undefined: psum_cnt port and counter absent; all other behaviour identical.

Verification
REQ-033 NACC=2, out_ready=1, acc 0x11, 0x22 then pkt 0x33 -> out_data 0x11,0x22,0x33 on consecutive cycles, out_last high only with 0x33.
REQ-034 pkt_valid=1 with 0x55 from cycle 0, acc 0x01,0x02 arriving later -> pkt_ready stays 0 until both acc accepted; output 0x01,0x02,0x55.
REQ-035 out_ready=0 for 5 cycles holding 0x22 -> out_data stable at 0x22, acc_ready=pkt_ready=0; release -> 0x22 transferred once, no duplicate.
REQ-036 Reset pulse after acc 0xAA accepted -> out_valid=0 within reset; next words 0xB1,0xB2,pkt 0xB3 -> out_last only on 0xB3.
REQ-037 NACC=1, alternating acc/pkt streams of 4 groups -> strict alternation, out_last on every second word.
REQ-038 PE_MERGE_PSUM_CNT_EN defined, psum_cnt preset path via 65536 groups -> psum_cnt returns to 0x0000.
